// File: rtl/ethernet_head_rx_classifier.sv
// Captures the first 42 bytes of each received frame and classifies it as ARP, ICMP echo or UDP.
// Head and flags are presented one cycle after beat 5; no backpressure, every i_valid beat is consumed.
module ethernet_head_rx_classifier #(
    parameter logic [47:0] FPGA_MAC = 48'h211abcdef112,
    parameter logic [31:0] FPGA_IP  = 32'hC0000186
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_valid,
    input  logic [63:0]  i_data,
    input  logic         i_last,
    output logic [335:0] o_data_head,
    output logic         o_data_head_valid,
    output logic         o_arp_valid,
    output logic         o_icmp_valid,
    output logic         o_udp_valid,
    output logic [15:0]  o_drop_count
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SKIP
    } state_t;

    state_t         state, state_nxt;
    logic [2:0]     beat_cnt, cnt_nxt;
    logic [319:0]   cap_buf;
    logic           head_done;
    logic           drop;
    logic [335:0]   head_nxt;
    logic           unused_tail;

    // bytes 42-47 of beat 5 never contribute to the head
    assign unused_tail = ^i_data[47:0];

    // bytes 0-39 accumulate in cap_buf; beat 5 supplies bytes 40-41 directly
    assign head_nxt = {cap_buf, i_data[63:48]};

    logic [47:0] mac_dst;
    logic [15:0] ethertype;
    logic [7:0]  ver_ihl;
    logic [15:0] arp_oper;
    logic [7:0]  ip_proto;
    logic [31:0] ip_dst;
    logic [7:0]  icmp_type;
    logic [31:0] arp_tpa;
    logic        is_arp;
    logic        is_ipv4;
    logic        is_icmp;
    logic        is_udp;

    assign mac_dst   = head_nxt[335:288];
    assign ethertype = head_nxt[239:224];
    assign ver_ihl   = head_nxt[223:216];
    assign arp_oper  = head_nxt[175:160];
    assign ip_proto  = head_nxt[151:144];
    assign ip_dst    = head_nxt[95:64];
    assign icmp_type = head_nxt[63:56];
    assign arp_tpa   = head_nxt[31:0];

    assign is_arp  = (ethertype == 16'h0806) && (arp_oper == 16'h0001) && (arp_tpa == FPGA_IP)
                     && ((mac_dst == FPGA_MAC) || (mac_dst == 48'hFFFFFFFFFFFF));
    assign is_ipv4 = (ethertype == 16'h0800) && (ver_ihl == 8'h45)
                     && (mac_dst == FPGA_MAC) && (ip_dst == FPGA_IP);
    assign is_icmp = is_ipv4 && (ip_proto == 8'h01) && (icmp_type == 8'h08);
    assign is_udp  = is_ipv4 && (ip_proto == 8'h11);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = beat_cnt;
        head_done = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    if (i_last) begin
                        drop    = 1'b1;
                        cnt_nxt = 3'd0;
                    end else begin
                        cnt_nxt   = 3'd1;
                        state_nxt = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (i_valid) begin
                    if (beat_cnt == 3'd5) begin
                        head_done = 1'b1;
                        cnt_nxt   = 3'd0;
                        state_nxt = i_last ? IDLE : SKIP;
                    end else if (i_last) begin
                        drop      = 1'b1;
                        cnt_nxt   = 3'd0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = beat_cnt + 3'd1;
                    end
                end
            end
            SKIP: begin
                if (i_valid && i_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state             <= IDLE;
            beat_cnt          <= 3'd0;
            cap_buf           <= '0;
            o_data_head       <= '0;
            o_data_head_valid <= 1'b0;
            o_arp_valid       <= 1'b0;
            o_icmp_valid      <= 1'b0;
            o_udp_valid       <= 1'b0;
            o_drop_count      <= 16'd0;
        end else begin
            state             <= state_nxt;
            beat_cnt          <= cnt_nxt;
            if (i_valid && (state != SKIP)) begin
                cap_buf <= {cap_buf[255:0], i_data};
            end
            o_data_head_valid <= head_done;
            o_arp_valid       <= head_done && is_arp;
            o_icmp_valid      <= head_done && is_icmp;
            o_udp_valid       <= head_done && is_udp;
            if (head_done) begin
                o_data_head <= head_nxt;
            end
            if (drop && (o_drop_count != 16'hFFFF)) begin
                o_drop_count <= o_drop_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ethernet_head_rx_classifier.sv
// Directed table of frame headers plus hand-written sequences for short frames, gaps, back-to-back and reset.
module tb_ethernet_head_rx_classifier;

    localparam logic [47:0] MAC   = 48'h211abcdef112;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
    localparam logic [31:0] IP    = 32'hC0000186;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid;
    logic [63:0]  i_data;
    logic         i_last;
    logic [335:0] o_data_head;
    logic         o_data_head_valid;
    logic         o_arp_valid;
    logic         o_icmp_valid;
    logic         o_udp_valid;
    logic [15:0]  o_drop_count;

    always #5 clk = ~clk;

    ethernet_head_rx_classifier dut (
        .i_clk             (clk),
        .i_reset_n         (rst_n),
        .i_valid           (i_valid),
        .i_data            (i_data),
        .i_last            (i_last),
        .o_data_head       (o_data_head),
        .o_data_head_valid (o_data_head_valid),
        .o_arp_valid       (o_arp_valid),
        .o_icmp_valid      (o_icmp_valid),
        .o_udp_valid       (o_udp_valid),
        .o_drop_count      (o_drop_count)
    );

    typedef struct {
        string       name;
        logic [15:0] etype;
        logic [47:0] mac;
        logic [15:0] oper;
        logic [7:0]  ver;
        logic [7:0]  proto;
        logic [7:0]  icmpt;
        logic [31:0] ip;
        logic [2:0]  exp_flags;   // {arp, icmp, udp}
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int stamps[$];
    logic [335:0] cap_head;
    logic [2:0]   cap_flags;
    logic [7:0]   frm [0:63];
    vec_t         vt [13];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (o_data_head_valid) begin
            pulse_cnt++;
            cap_head  = o_data_head;
            cap_flags = {o_arp_valid, o_icmp_valid, o_udp_valid};
            stamps.push_back(cyc);
        end else begin
            checks++;
            if ({o_arp_valid, o_icmp_valid, o_udp_valid} != 3'b000) begin
                errors++;
                $display("FAIL flags_without_valid act=%b req=000",
                         {o_arp_valid, o_icmp_valid, o_udp_valid});
            end
        end
    end

    task automatic chk(input string name, input logic [335:0] act, input logic [335:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [15:0] etype, input logic [47:0] mac,
                                input logic [15:0] oper, input logic [7:0] ver, input logic [7:0] proto,
                                input logic [7:0] icmpt, input logic [31:0] ip, input logic [2:0] fl);
        vec_t v;
        v.name = name; v.etype = etype; v.mac = mac; v.oper = oper; v.ver = ver;
        v.proto = proto; v.icmpt = icmpt; v.ip = ip; v.exp_flags = fl;
        return v;
    endfunction

    task automatic build_frame(input vec_t v);
        for (int k = 0; k < 64; k++) frm[k] = 8'((k * 7) + 3);
        for (int k = 0; k < 6; k++) frm[k] = v.mac[47 - 8*k -: 8];
        for (int k = 0; k < 6; k++) frm[6 + k] = 8'(8'h02 + k);
        frm[12] = v.etype[15:8];
        frm[13] = v.etype[7:0];
        if (v.etype == 16'h0806) begin
            frm[20] = v.oper[15:8];
            frm[21] = v.oper[7:0];
            for (int k = 0; k < 4; k++) frm[38 + k] = v.ip[31 - 8*k -: 8];
        end else begin
            frm[14] = v.ver;
            frm[23] = v.proto;
            for (int k = 0; k < 4; k++) frm[30 + k] = v.ip[31 - 8*k -: 8];
            frm[34] = v.icmpt;
        end
    endtask

    function automatic logic [335:0] exp_head();
        logic [335:0] h = '0;
        for (int k = 0; k < 42; k++) h = {h[327:0], frm[k]};
        return h;
    endfunction

    function automatic logic [63:0] beat(input int b);
        logic [63:0] d = '0;
        for (int k = 0; k < 8; k++) d = {d[55:0], frm[8*b + k]};
        return d;
    endfunction

    task automatic send_frame(input int nbeats, input int gap, input bit idle_after);
        for (int b = 0; b < nbeats; b++) begin
            @(posedge clk); #1;
            i_valid = 1'b1;
            i_data  = beat(b);
            i_last  = (b == nbeats - 1);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                i_valid = 1'b0;
                i_data  = {$urandom, $urandom};
                i_last  = 1'($urandom_range(0, 1));
            end
        end
        if (idle_after) begin
            @(posedge clk); #1;
            i_valid = 1'b0;
            i_last  = 1'b0;
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [335:0] h_a, h_b, h_prev;

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_last  = 1'b0;

        vt[0]  = mk("arp_bcast",   16'h0806, BCAST, 16'h0001, 8'h00, 8'h00, 8'h00, IP,           3'b100);
        vt[1]  = mk("arp_ucast",   16'h0806, MAC,   16'h0001, 8'h00, 8'h00, 8'h00, IP,           3'b100);
        vt[2]  = mk("arp_reply",   16'h0806, BCAST, 16'h0002, 8'h00, 8'h00, 8'h00, IP,           3'b000);
        vt[3]  = mk("arp_tpa_x",   16'h0806, BCAST, 16'h0001, 8'h00, 8'h00, 8'h00, 32'hC0000187, 3'b000);
        vt[4]  = mk("arp_mac_x",   16'h0806, 48'h001122334455, 16'h0001, 8'h00, 8'h00, 8'h00, IP, 3'b000);
        vt[5]  = mk("udp_ip_x",    16'h0800, MAC,   16'h0000, 8'h45, 8'h11, 8'h00, 32'hC0000187, 3'b000);
        vt[6]  = mk("udp_ok",      16'h0800, MAC,   16'h0000, 8'h45, 8'h11, 8'h00, IP,           3'b001);
        vt[7]  = mk("icmp_echo",   16'h0800, MAC,   16'h0000, 8'h45, 8'h01, 8'h08, IP,           3'b010);
        vt[8]  = mk("icmp_reply",  16'h0800, MAC,   16'h0000, 8'h45, 8'h01, 8'h00, IP,           3'b000);
        vt[9]  = mk("udp_bcast",   16'h0800, BCAST, 16'h0000, 8'h45, 8'h11, 8'h00, IP,           3'b000);
        vt[10] = mk("ipv4_opts",   16'h0800, MAC,   16'h0000, 8'h46, 8'h11, 8'h00, IP,           3'b000);
        vt[11] = mk("tcp",         16'h0800, MAC,   16'h0000, 8'h45, 8'h06, 8'h00, IP,           3'b000);
        vt[12] = mk("vlan",        16'h8100, MAC,   16'h0000, 8'h45, 8'h11, 8'h00, IP,           3'b000);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_head",  o_data_head, '0);
        chk("rst_valid", {335'd0, o_data_head_valid}, '0);
        chk("rst_flags", {333'd0, o_arp_valid, o_icmp_valid, o_udp_valid}, '0);
        chk("rst_drop",  {320'd0, o_drop_count}, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            build_frame(vt[i]);
            pulse_cnt = 0;
            send_frame(8, 0, 1'b1);
            settle();
            chk({vt[i].name, "_pulses"}, 336'(pulse_cnt), 336'd1);
            chk({vt[i].name, "_flags"},  {333'd0, cap_flags}, {333'd0, vt[i].exp_flags});
            chk({vt[i].name, "_head"},   cap_head, exp_head());
            if (i == 0) chk("arp_bcast_macdst", {288'd0, cap_head[335:288]}, {288'd0, BCAST});
        end

        // ICMP echo with a dead cycle between every beat
        build_frame(vt[7]);
        pulse_cnt = 0;
        send_frame(8, 1, 1'b1);
        settle();
        chk("gap_pulses", 336'(pulse_cnt), 336'd1);
        chk("gap_flags",  {333'd0, cap_flags}, {333'd0, 3'b010});
        chk("gap_byte34", {328'd0, cap_head[63:56]}, {328'd0, 8'h08});
        h_prev = exp_head();

        // last on beat 3: dropped, previous head held
        build_frame(vt[6]);
        pulse_cnt = 0;
        send_frame(4, 0, 1'b1);
        settle();
        chk("short_pulses", 336'(pulse_cnt), 336'd0);
        chk("short_drop",   {320'd0, o_drop_count}, {320'd0, 16'd1});
        chk("short_hold",   o_data_head, h_prev);

        // single-beat frame is dropped from IDLE
        send_frame(1, 0, 1'b1);
        settle();
        chk("one_beat_drop", {320'd0, o_drop_count}, {320'd0, 16'd2});

        // two back-to-back 6-beat frames
        build_frame(vt[0]);
        h_a = exp_head();
        pulse_cnt = 0;
        stamps.delete();
        send_frame(6, 0, 1'b0);
        build_frame(vt[6]);
        h_b = exp_head();
        send_frame(6, 0, 1'b1);
        settle();
        chk("b2b_pulses", 336'(pulse_cnt), 336'd2);
        if (stamps.size() == 2) chk("b2b_spacing", 336'(stamps[1] - stamps[0]), 336'd6);
        else chk("b2b_stamps", 336'(stamps.size()), 336'd2);
        chk("b2b_head2",  cap_head, h_b);
        chk("b2b_flags2", {333'd0, cap_flags}, {333'd0, 3'b001});
        chk("b2b_drop",   {320'd0, o_drop_count}, {320'd0, 16'd2});

        // reset asserted while beat 2 of a frame is on the bus
        build_frame(vt[6]);
        send_frame(2, 0, 1'b0);
        @(posedge clk); #1;
        i_valid = 1'b1;
        i_data  = beat(2);
        i_last  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_head",  o_data_head, '0);
        chk("mid_rst_valid", {335'd0, o_data_head_valid}, '0);
        chk("mid_rst_drop",  {320'd0, o_drop_count}, '0);
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_flags", {333'd0, o_arp_valid, o_icmp_valid, o_udp_valid}, '0);
        rst_n = 1'b1;
        pulse_cnt = 0;
        build_frame(vt[0]);
        send_frame(8, 0, 1'b1);
        settle();
        chk("post_rst_pulses", 336'(pulse_cnt), 336'd1);
        chk("post_rst_head",   cap_head, exp_head());
        chk("post_rst_flags",  {333'd0, cap_flags}, {333'd0, 3'b100});
        chk("post_rst_drop",   {320'd0, o_drop_count}, '0);

        // saturate the drop counter with single-beat frames
        @(posedge clk); #1;
        i_valid = 1'b1;
        i_last  = 1'b1;
        repeat (65537) @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        chk("drop_sat", {320'd0, o_drop_count}, {320'd0, 16'hFFFF});
        build_frame(vt[6]);
        send_frame(4, 0, 1'b1);
        settle();
        chk("drop_sat_hold", {320'd0, o_drop_count}, {320'd0, 16'hFFFF});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
